// File: rtl/uart_num_printer.sv
// uart_num_printer: latches NUM signed 16-bit samples on a strobe and streams them
// as one line of signed decimal ASCII over a valid/ready byte handshake.
`timescale 1ns/1ps
module uart_num_printer #(
    parameter int         NUM = 4,
    parameter logic [7:0] SEP = 8'h20
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_en,
    input  logic [16*NUM-1:0] i_data,
    output logic              o_busy,
    output logic              o_e,
    input  logic              o_r,
    output logic [7:0]        o_d
);
    typedef enum logic [2:0] {IDLE, CONV, SIGN, DIGIT, SEPB} state_t;
    localparam logic [1:0] LAST = 2'(NUM - 1);

    state_t            state_r;
    logic [16*NUM-1:0] data_r;
    logic [1:0]        idx_r;
    logic [15:0]       bin_r;
    logic [19:0]       bcd_r;
    logic [3:0]        cnt_r;
    logic              neg_r;
    logic [2:0]        dig_r;

    logic [63:0]       data_ext_s;
    logic [15:0]       next_val_s;
    logic [19:0]       bcd_adj_s;
    logic [19:0]       bcd_shift_s;
    logic [2:0]        top_s;

    function automatic logic [15:0] abs16(input logic [15:0] v);
        if (v[15]) begin
            return 16'd0 - v;
        end else begin
            return v;
        end
    endfunction

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [19:0] add3(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int i = 0; i < 5; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = r[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] top_digit(input logic [19:0] b);
        logic [2:0] t;
        t = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (b[4*i +: 4] != 4'd0) begin
                t = 3'(i);
            end else begin
                t = t;
            end
        end
        return t;
    endfunction

    function automatic logic [7:0] ascii(input logic [19:0] b, input logic [2:0] idx);
        return 8'h30 + {4'h0, b[{idx, 2'b00} +: 4]};
    endfunction

    // Next-value selection and one double-dabble step for the conversion state.
    always_comb begin
        data_ext_s                = 64'h0;
        data_ext_s[16*NUM-1:0]    = data_r;
        next_val_s                = data_ext_s[{idx_r + 2'd1, 4'h0} +: 16];
        bcd_adj_s                 = add3(bcd_r);
        bcd_shift_s               = 20'({bcd_adj_s, bin_r[15]});
        top_s                     = top_digit(bcd_shift_s);
    end

    // Line sequencer: convert, then emit sign, digits and separator per value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            data_r  <= '0;
            idx_r   <= 2'd0;
            bin_r   <= 16'd0;
            bcd_r   <= 20'd0;
            cnt_r   <= 4'd0;
            neg_r   <= 1'b0;
            dig_r   <= 3'd0;
            o_busy  <= 1'b0;
            o_e     <= 1'b0;
            o_d     <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_en) begin
                        data_r  <= i_data;
                        idx_r   <= 2'd0;
                        neg_r   <= i_data[15];
                        bin_r   <= abs16(i_data[15:0]);
                        bcd_r   <= 20'd0;
                        cnt_r   <= 4'd0;
                        o_busy  <= 1'b1;
                        state_r <= CONV;
                    end
                end
                CONV: begin
                    bcd_r <= bcd_shift_s;
                    bin_r <= {bin_r[14:0], 1'b0};
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == 4'd15) begin
                        dig_r <= top_s;
                        o_e   <= 1'b1;
                        if (neg_r) begin
                            o_d     <= 8'h2D;
                            state_r <= SIGN;
                        end else begin
                            o_d     <= ascii(bcd_shift_s, top_s);
                            state_r <= DIGIT;
                        end
                    end
                end
                SIGN: begin
                    if (o_r) begin
                        o_d     <= ascii(bcd_r, dig_r);
                        state_r <= DIGIT;
                    end
                end
                DIGIT: begin
                    if (o_r) begin
                        if (dig_r == 3'd0) begin
                            o_d     <= (idx_r == LAST) ? 8'h0A : SEP;
                            state_r <= SEPB;
                        end else begin
                            dig_r <= dig_r - 3'd1;
                            o_d   <= ascii(bcd_r, dig_r - 3'd1);
                        end
                    end
                end
                SEPB: begin
                    if (o_r) begin
                        o_e <= 1'b0;
                        if (idx_r == LAST) begin
                            o_busy  <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            idx_r   <= idx_r + 2'd1;
                            neg_r   <= next_val_s[15];
                            bin_r   <= abs16(next_val_s);
                            bcd_r   <= 20'd0;
                            cnt_r   <= 4'd0;
                            state_r <= CONV;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    o_busy  <= 1'b0;
                    o_e     <= 1'b0;
                    o_d     <= 8'h00;
                end
            endcase
        end
    end
endmodule
